// File: rtl/elixirchip_es1_spu_op_reg_arbiter_if.sv
// Requester/op_reg bus bundle for elixirchip_es1_spu_op_reg_arbiter.
// slave  : arbiter view (takes requests and the op_reg result, drives grants, issue and return).
// master : environment view (requesters, the shared op_reg and the result consumer).
// Signals:
//   s_data/s_clear/s_valid  per-requester write data, clear request, write request
//   s_ready                 one-hot grant
//   op_data/op_clear/op_valid  command issued to the shared op_reg
//   op_m_data               op_reg result
//   m_data/m_id/m_valid     result returned to the requester side
interface elixirchip_es1_spu_op_reg_arbiter_if #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned DATA_BITS = 8
);
  localparam int unsigned ID_BITS = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ*DATA_BITS-1:0] s_data;
  logic [NUM_REQ-1:0]           s_clear;
  logic [NUM_REQ-1:0]           s_valid;
  logic [NUM_REQ-1:0]           s_ready;

  logic [DATA_BITS-1:0]         op_data;
  logic                         op_clear;
  logic                         op_valid;
  logic [DATA_BITS-1:0]         op_m_data;

  logic [DATA_BITS-1:0]         m_data;
  logic [ID_BITS-1:0]           m_id;
  logic                         m_valid;

  modport slave (
    input  s_data, s_clear, s_valid, op_m_data,
    output s_ready, op_data, op_clear, op_valid, m_data, m_id, m_valid
  );

  modport master (
    output s_data, s_clear, s_valid, op_m_data,
    input  s_ready, op_data, op_clear, op_valid, m_data, m_id, m_valid
  );
endinterface

// File: rtl/elixirchip_es1_spu_op_reg_arbiter.sv
// Round-robin arbiter sharing one op_reg among NUM_REQ requesters.
// Grants one write/clear per enabled cycle, registers the issued command, and
// tags each write's result with its requester ID after the op_reg latency.
// Ports:
//   clk      clock, rising edge
//   reset_n  asynchronous active-low reset
//   cke      clock enable; all state holds while low
//   bus      requester / op_reg / result bundle (slave view)
module elixirchip_es1_spu_op_reg_arbiter #(
  parameter int unsigned          NUM_REQ    = 4,
  parameter int                   LATENCY    = 1,
  parameter int unsigned          DATA_BITS  = 8,
  parameter logic [DATA_BITS-1:0] CLEAR_DATA = '0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic cke,
  elixirchip_es1_spu_op_reg_arbiter_if.slave bus
);

  localparam int unsigned ID_BITS  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned SUM_BITS = ID_BITS + 1;
  localparam int unsigned TRK_LEN  = (LATENCY >= 1) ? LATENCY : 1;

  if (LATENCY < 1) begin : g_bad_latency
    $error("elixirchip_es1_spu_op_reg_arbiter: LATENCY must be >= 1");
  end
  if (NUM_REQ < 2 || NUM_REQ > 16) begin : g_bad_num_req
    $error("elixirchip_es1_spu_op_reg_arbiter: NUM_REQ must be 2..16");
  end

  logic [ID_BITS-1:0]   rr_ptr_q, rr_ptr_d;
  logic [DATA_BITS-1:0] op_data_q, op_data_d;
  logic                 op_clear_q, op_clear_d;
  logic                 op_valid_q, op_valid_d;
  logic [ID_BITS-1:0]   op_id_q, op_id_d;

  logic [TRK_LEN-1:0]   trk_valid_q;
  logic [ID_BITS-1:0]   trk_id_q [TRK_LEN];

  logic [NUM_REQ-1:0]   req_c;
  logic [SUM_BITS-1:0]  idx_c;
  logic                 gnt_found_c;
  logic [ID_BITS-1:0]   gnt_idx_c;
  logic                 accept_c;

  // First requesting index at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    req_c       = bus.s_valid | bus.s_clear;
    gnt_found_c = 1'b0;
    gnt_idx_c   = '0;
    idx_c       = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx_c = SUM_BITS'(rr_ptr_q) + SUM_BITS'(k);
      if (idx_c >= SUM_BITS'(NUM_REQ)) begin
        idx_c = idx_c - SUM_BITS'(NUM_REQ);
      end
      if (!gnt_found_c && req_c[idx_c[ID_BITS-1:0]]) begin
        gnt_found_c = 1'b1;
        gnt_idx_c   = idx_c[ID_BITS-1:0];
      end
    end
  end

  assign accept_c    = cke & reset_n & gnt_found_c;
  assign bus.s_ready = accept_c ? (NUM_REQ'(1) << gnt_idx_c) : '0;

  // Issue register and pointer next state; clear wins over write within a requester.
  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    op_data_d  = op_data_q;
    op_clear_d = 1'b0;
    op_valid_d = 1'b0;
    op_id_d    = op_id_q;
    if (accept_c) begin
      rr_ptr_d = (gnt_idx_c == ID_BITS'(NUM_REQ - 1)) ? '0 : gnt_idx_c + ID_BITS'(1);
      op_id_d  = gnt_idx_c;
      if (bus.s_clear[gnt_idx_c]) begin
        op_clear_d = 1'b1;
      end else begin
        op_valid_d = 1'b1;
        op_data_d  = bus.s_data[gnt_idx_c*DATA_BITS +: DATA_BITS];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr_q   <= '0;
      op_data_q  <= CLEAR_DATA;
      op_clear_q <= 1'b0;
      op_valid_q <= 1'b0;
      op_id_q    <= '0;
    end else if (cke) begin
      rr_ptr_q   <= rr_ptr_d;
      op_data_q  <= op_data_d;
      op_clear_q <= op_clear_d;
      op_valid_q <= op_valid_d;
      op_id_q    <= op_id_d;
    end
  end

  // Return tracker mirrors the op_reg latency; clears enter with valid=0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      trk_valid_q <= '0;
      for (int i = 0; i < int'(TRK_LEN); i++) begin
        trk_id_q[i] <= '0;
      end
    end else if (cke) begin
      for (int i = int'(TRK_LEN) - 1; i > 0; i--) begin
        trk_valid_q[i] <= trk_valid_q[i-1];
        trk_id_q[i]    <= trk_id_q[i-1];
      end
      trk_valid_q[0] <= op_valid_q;
      trk_id_q[0]    <= op_id_q;
    end
  end

  assign bus.op_data  = op_data_q;
  assign bus.op_clear = op_clear_q;
  assign bus.op_valid = op_valid_q;
  assign bus.m_data   = bus.op_m_data;
  assign bus.m_valid  = trk_valid_q[TRK_LEN-1];
  assign bus.m_id     = trk_id_q[TRK_LEN-1];

endmodule

// File: tb/tb_elixirchip_es1_spu_op_reg_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic against a
// transaction-level model (grant search, issue state, result scoreboard).
module tb_elixirchip_es1_spu_op_reg_arbiter;
  localparam int NR  = 4;
  localparam int DB  = 8;
  localparam int LAT = 3;

  logic clk = 1'b0;
  logic reset_n;
  logic cke;

  elixirchip_es1_spu_op_reg_arbiter_if #(.NUM_REQ(NR), .DATA_BITS(DB)) bus ();

  elixirchip_es1_spu_op_reg_arbiter #(
    .NUM_REQ(NR), .LATENCY(LAT), .DATA_BITS(DB), .CLEAR_DATA('0)
  ) dut (
    .clk(clk), .reset_n(reset_n), .cke(cke), .bus(bus.slave)
  );

  always #5 clk = ~clk;

  // Shared op_reg stand-in: captures the issued command, then LAT-1 more delay stages.
  logic [DB-1:0] opr_q [LAT];
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < LAT; i++) opr_q[i] <= '0;
    end else if (cke) begin
      for (int i = LAT - 1; i > 0; i--) opr_q[i] <= opr_q[i-1];
      if (bus.op_clear) opr_q[0] <= '0;
      else if (bus.op_valid) opr_q[0] <= bus.op_data;
    end
  end
  assign bus.op_m_data = opr_q[LAT-1];

  typedef struct {int due; int id; logic [DB-1:0] data;} res_t;
  res_t sb[$];

  int n_chk = 0;
  int n_pass = 0;
  int rr, ecnt;
  bit exp_opv, exp_opc;
  logic [DB-1:0] exp_opd;
  bit pend_v [NR];
  bit pend_c [NR];
  logic [DB-1:0] pend_d [NR];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    rr = 0;
    exp_opv = 0;
    exp_opc = 0;
    exp_opd = '0;
    sb.delete();
    for (int i = 0; i < NR; i++) begin
      pend_v[i] = 0;
      pend_c[i] = 0;
      pend_d[i] = '0;
    end
  endtask

  function automatic bit any_pend();
    bit a = 0;
    for (int i = 0; i < NR; i++) if (pend_v[i] || pend_c[i]) a = 1;
    return a;
  endfunction

  // One clock: drive at negedge, check at +1, update the model at posedge.
  task automatic cycle(input bit cke_v);
    int g;
    bit mv;
    int mid;
    logic [DB-1:0] md;
    logic [NR-1:0] exp_rdy;
    cke = cke_v;
    for (int i = 0; i < NR; i++) begin
      bus.s_valid[i] = pend_v[i];
      bus.s_clear[i] = pend_c[i];
      bus.s_data[i*DB +: DB] = pend_d[i];
    end
    #1;
    g = -1;
    for (int k = 0; k < NR; k++) begin
      int idx = (rr + k) % NR;
      if (g < 0 && (pend_v[idx] || pend_c[idx])) g = idx;
    end
    exp_rdy = '0;
    if (cke_v && g >= 0) exp_rdy[g] = 1'b1;
    chk("s_ready", 32'(bus.s_ready), 32'(exp_rdy));
    chk("op_valid", 32'(bus.op_valid), 32'(exp_opv));
    chk("op_clear", 32'(bus.op_clear), 32'(exp_opc));
    chk("op_data", 32'(bus.op_data), 32'(exp_opd));
    while (sb.size() > 0 && sb[0].due < ecnt) void'(sb.pop_front());
    mv = 0;
    mid = 0;
    md = '0;
    if (sb.size() > 0 && sb[0].due == ecnt) begin
      mv = 1;
      mid = sb[0].id;
      md = sb[0].data;
    end
    chk("m_valid", 32'(bus.m_valid), 32'(mv));
    if (mv) begin
      chk("m_id", 32'(bus.m_id), 32'(mid));
      chk("m_data", 32'(bus.m_data), 32'(md));
    end
    @(posedge clk);
    if (cke_v) begin
      if (g >= 0) begin
        if (pend_c[g]) begin
          exp_opc = 1;
          exp_opv = 0;
        end else begin
          exp_opc = 0;
          exp_opv = 1;
          exp_opd = pend_d[g];
          sb.push_back('{due: ecnt + 1 + LAT, id: g, data: pend_d[g]});
        end
        rr = (g + 1) % NR;
        pend_v[g] = 0;
        pend_c[g] = 0;
      end else begin
        exp_opc = 0;
        exp_opv = 0;
      end
      ecnt++;
    end
    @(negedge clk);
  endtask

  task automatic run_until_idle(input int budget);
    int n = 0;
    while (any_pend() && n < budget) begin
      cycle(1'b1);
      n++;
    end
    chk("drain_timeout", 32'(any_pend()), 32'd0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1);
  endtask

  task automatic put(input int i, input bit v, input bit c, input logic [DB-1:0] d);
    pend_v[i] = v;
    pend_c[i] = c;
    pend_d[i] = d;
  endtask

  initial begin
    logic [DB-1:0] seq [3];
    bit pat [6];
    int p, nw, budget;
    seq[0] = 8'h11; seq[1] = 8'h22; seq[2] = 8'h33;
    pat[0] = 1; pat[1] = 0; pat[2] = 1; pat[3] = 1; pat[4] = 0; pat[5] = 1;
    ecnt = 0;
    model_reset();
    reset_n = 1'b0;
    cke = 1'b0;
    bus.s_valid = '0;
    bus.s_clear = '0;
    bus.s_data = '0;
    repeat (2) @(negedge clk);

    // Reset state: grants suppressed even with every requester asking.
    cke = 1'b1;
    bus.s_valid = '1;
    #1;
    chk("rst_s_ready", 32'(bus.s_ready), 32'd0);
    chk("rst_op_valid", 32'(bus.op_valid), 32'd0);
    chk("rst_op_clear", 32'(bus.op_clear), 32'd0);
    chk("rst_op_data", 32'(bus.op_data), 32'd0);
    chk("rst_m_valid", 32'(bus.m_valid), 32'd0);
    chk("rst_m_id", 32'(bus.m_id), 32'd0);
    @(negedge clk);
    bus.s_valid = '0;
    reset_n = 1'b1;

    // Single requester 2 streaming three writes.
    for (int k = 0; k < 3; k++) begin
      put(2, 1, 0, seq[k]);
      run_until_idle(4);
    end
    idle(LAT + 2);

    // All four requesting, two full rotations.
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < NR; i++) put(i, 1, 0, DB'(8'hA0 + i));
      run_until_idle(8);
    end
    idle(LAT + 2);

    // Clear from 1, then write 0x5A from 3.
    put(1, 0, 1, 8'h77);
    run_until_idle(4);
    put(3, 1, 0, 8'h5A);
    run_until_idle(4);
    idle(LAT + 2);

    // Write burst with a toggling clock enable.
    p = 0;
    nw = 0;
    budget = 0;
    while (nw < 5 && budget < 40) begin
      if (!pend_v[0]) begin
        put(0, 1, 0, DB'(8'hC0 + nw));
        nw++;
      end
      cycle(pat[p]);
      p = (p + 1) % 6;
      budget++;
    end
    run_until_idle(8);
    for (int i = 0; i < 8; i++) cycle(pat[i % 6]);
    idle(LAT + 2);

    // Asynchronous reset with writes in flight.
    put(1, 1, 0, 8'h31);
    put(2, 1, 0, 8'h32);
    run_until_idle(4);
    cke = 1'b1;
    bus.s_valid = '1;
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_s_ready", 32'(bus.s_ready), 32'd0);
    chk("arst_op_valid", 32'(bus.op_valid), 32'd0);
    chk("arst_m_valid", 32'(bus.m_valid), 32'd0);
    chk("arst_m_id", 32'(bus.m_id), 32'd0);
    model_reset();
    @(negedge clk);
    bus.s_valid = '0;
    reset_n = 1'b1;
    for (int i = 0; i < NR; i++) put(i, 1, 0, DB'(8'h40 + i));
    cycle(1'b1);
    chk("post_rst_grant_left", 32'(pend_v[0]), 32'd0);
    run_until_idle(8);
    idle(LAT + 2);

    // Valid and clear together: one grant served as a clear.
    put(0, 1, 1, 8'hFF);
    run_until_idle(4);
    idle(LAT + 2);

    // Random traffic with random clock enable.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NR; i++) begin
        if (!pend_v[i] && !pend_c[i] && $urandom_range(0, 1) == 1) begin
          int t = $urandom_range(0, 19);
          put(i, t < 17, t >= 14, DB'($urandom));
        end
      end
      cycle($urandom_range(0, 4) != 0);
    end
    run_until_idle(16);
    idle(LAT + 2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/elixirchip_es1_spu_op_reg_arbiter.md
# elixirchip_es1_spu_op_reg_arbiter

Round-robin arbiter that shares one `elixirchip_es1_spu_op_reg` instance among `NUM_REQ` requesters. It accepts write and clear commands through per-requester handshakes, issues one command per enabled clock to the shared register, and returns each write's registered result tagged with the requester ID after the register's latency. It sits between SPU issue lanes and a single op_reg resource.

## Interface
- `NUM_REQ`, 4: number of requesters; must be 2..16.
- `LATENCY`, 1: latency of the attached op_reg; must be ≥1, with elaboration `$error` otherwise.
- `DATA_BITS`, 8: data width.
- `CLEAR_DATA`, '0: reset value of `op_data`; must match the op_reg `CLEAR_DATA`.
- `ID_BITS`, derived: `$clog2(NUM_REQ)`.
- `clk` in 1: clock, rising edge.
- `reset_n` in 1: reset, asynchronous, active-low.
- `cke` in 1: clock enable; all state holds when it is 0.
- `s_data` in NUM_REQ*DATA_BITS: per-requester write data; requester i uses bits [i*DATA_BITS +: DATA_BITS].
- `s_clear` in NUM_REQ: per-requester clear request.
- `s_valid` in NUM_REQ: per-requester write request.
- `s_ready` out NUM_REQ: one-hot grant.
- `op_data` out DATA_BITS: to op_reg `s_data`.
- `op_clear` out 1: to op_reg `s_clear`.
- `op_valid` out 1: to op_reg `s_valid`.
- `op_m_data` in DATA_BITS: from op_reg `m_data`.
- `m_data` out DATA_BITS: result, equal to `op_m_data` (combinational pass-through).
- `m_id` out ID_BITS: requester that issued the write now appearing on `m_data`.
- `m_valid` out 1: result valid, one cycle per accepted write.

## Operation
- Requester i is requesting when `s_valid[i] | s_clear[i]`.
- Arbitration:
  - Round-robin starting at pointer `rr_ptr`.
  - The granted index g is the first requesting index at or after `rr_ptr`, modulo NUM_REQ.
  - `s_ready` is combinational from `rr_ptr` and the requests.
  - `s_ready` is all-zero when `cke=0` or when no requester is requesting.
- Acceptance: when `cke & s_ready[g]`, the request is accepted and `rr_ptr <= (g+1) % NUM_REQ`. The wrap from NUM_REQ-1 goes to 0. With no acceptance, `rr_ptr` holds.
- Issue register, updated on an acceptance cycle with `cke=1`:
  - Clear wins within a requester. If `s_clear[g]=1`: `op_clear<=1`, `op_valid<=0`, `op_data` holds.
  - Otherwise: `op_valid<=1`, `op_clear<=0`, `op_data<=s_data[g]`.
  - With no acceptance: `op_valid<=0`, `op_clear<=0`, `op_data` holds.
- Return tracking:
  - LATENCY-stage shift register of {valid, id}, advanced only on `cke`.
  - Stage 0 loads {`op_valid`, id of the issued command}.
  - `m_valid`/`m_id` are the last stage.
  - Clears produce no `m_valid`.
- Requesters hold `s_data`/`s_valid`/`s_clear` until `s_ready`; a dropped request is simply not served.
- Reset (`reset_n=0`, asynchronous), effective immediately:
  - `rr_ptr=0`, `op_valid=0`, `op_clear=0`, `op_data=CLEAR_DATA`.
  - All tracking stages are {0, 0}, so `m_valid=0` and `m_id=0`.
  - In-flight results are discarded.
  - `s_ready` is forced to 0 while reset is asserted.

## Timing
- Handshake at cke-cycle t. `op_*` are valid in t+1, and the op_reg output updates at t+1+LATENCY.
- `m_valid` and `m_id` assert in cke-cycle t+1+LATENCY, so handshake-to-result is LATENCY+1 enabled cycles.
- Throughput is one accepted command per enabled cycle, whatever the mix of requesters.
- Stall: with `cke=0`, the pointer, issue register and shift register all freeze. `m_valid` holds its value but is qualified by `cke` downstream.
- Simultaneous `s_valid[i]` and `s_clear[i]` form one request, served as a clear and consuming one grant.
- Reset deassertion is synchronised externally; the first grant is possible in the first `cke` cycle after release.

## Test plan
- Single requester 2, `s_valid` held with data 0x11, 0x22, 0x33; LATENCY=1 -> `s_ready=4'b0100` every cycle; `m_valid` from cycle t+2 with `m_id=2` and `m_data` 0x11, 0x22, 0x33 in order.
- All 4 requesting continuously, data = 0xA0+i -> grants rotate 0,1,2,3,0 (pointer wrap); `m_id` sequence is 0,1,2,3,0 with matching `m_data`.
- Requester 1 sends clear, then requester 3 sends write 0x5A -> first command gives `op_clear=1` and no `m_valid`; second gives `m_valid` with `m_id=3` and `m_data=0x5A`.
- LATENCY=3, `cke` toggling 1,0,1,1,0,1 during a write burst -> `m_valid` appears exactly 4 enabled cycles after each handshake; no grants while `cke=0`.
- `reset_n` pulled low with 2 writes in flight -> `m_valid=0`, `s_ready=0` and `op_valid=0` asynchronously; after release the first grant goes to requester 0.
- Requester 0 with both `s_valid` and `s_clear` at data 0xFF -> one grant, `op_clear=1`, `op_valid=0`, no `m_valid`.
